token_div_sched: RTL

Shared token-divider scheduler: accepts single-cycle token pulses on N_CH independent channels and emits one output token per DIV input tokens on each channel. All channels share a single output port with a valid/ready handshake, granted round-robin. It sits between per-channel token sources and a single downstream consumer. With DIV=2 each channel's output count equals floor(input count / 2), matching the team's halving semantics.

---
 rtl/token_sched_pkg.sv | 17 +
 rtl/token_div_sched_rr_arbiter.sv | 33 +++
 rtl/token_div_sched.sv | 111 +++++++++++
 3 files changed

// File: rtl/token_sched_pkg.sv
// Shared types and default sizing for the token-divider scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package token_sched_pkg;

    localparam int TS_N_CH  = 4;
    localparam int TS_DIV   = 2;
    localparam int TS_CNT_W = 4;
    localparam int TS_CH_W  = $clog2(TS_N_CH);

    typedef logic [TS_CH_W-1:0]  ch_idx_t;
    typedef logic [TS_CNT_W-1:0] credit_t;

    // Saturation point of a per-channel credit counter.
    localparam credit_t CREDIT_MAX = '1;

endpackage

// File: rtl/token_div_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first requester after last_grant, wrapping.
// Latency: purely combinational, the pointer register lives in the parent.
// Backpressure: none; the parent qualifies the grant with its load condition.
module rr_arbiter #(
    parameter int N_CH = 4,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] last_grant,
    output logic [N_CH-1:0] grant,
    output logic [CH_W-1:0] grant_idx,
    output logic            any_grant
);

    int w_idx;

    // Scan from last_grant+1 around the ring; the first requester found wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        w_idx     = 0;
        for (int k = 1; k <= N_CH; k++) begin
            w_idx = (int'(last_grant) + k) % N_CH;
            if (!any_grant && req[w_idx]) begin
                any_grant        = 1'b1;
                grant[w_idx]     = 1'b1;
                grant_idx        = CH_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/token_div_sched.sv
// Divides per-channel token pulses by DIV and serves the credits round-robin on one port.
// Latency: group-completing token at edge t -> b_valid after edge t+1 (2 cycles min).
// Backpressure: b_valid & ~b_ready holds b_valid/b_ch; credits keep accumulating, saturate, then flag pend_ovf.
module token_div_sched
    import token_sched_pkg::*;
#(
    parameter int N_CH  = TS_N_CH,
    parameter int DIV   = TS_DIV,
    parameter int CNT_W = TS_CNT_W,
    localparam int CH_W = $clog2(N_CH),
    localparam int PH_W = $clog2(DIV)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N_CH-1:0] a,
    output logic            b_valid,
    output logic [CH_W-1:0] b_ch,
    input  logic            b_ready,
    output logic [N_CH-1:0] pend_ovf,
    output logic            busy
);

    localparam logic [CNT_W-1:0] CMAX     = '1;
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(DIV - 1);

    logic [N_CH-1:0] w_gen;
    logic [N_CH-1:0] w_req;
    logic [N_CH-1:0] w_grant;
    logic [N_CH-1:0] w_take;
    logic [CH_W-1:0] w_gidx;
    logic            w_any;
    logic            w_load;

    logic            r_bvalid;
    logic [CH_W-1:0] r_bch;
    logic [CH_W-1:0] r_last;

    // The output register may take a new token when empty or being drained.
    assign w_load = ~r_bvalid | b_ready;
    assign w_take = w_grant & {N_CH{w_load & w_any}};

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [PH_W-1:0]  r_phase;
        logic [CNT_W-1:0] r_credit;
        logic             r_ovf;

        assign w_gen[i]    = en & a[i] & (r_phase == PH_LAST);
        assign w_req[i]    = (r_credit != '0);
        assign pend_ovf[i] = r_ovf;

        // Phase counts input tokens within the current group; partial groups are never flushed.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_phase <= '0;
            end else if (en & a[i]) begin
                r_phase <= w_gen[i] ? '0 : r_phase + 1'b1;
            end
        end

        // Credit counter: +1 on group completion, -1 on grant, net zero when both; saturates and flags loss.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_credit <= '0;
                r_ovf    <= 1'b0;
            end else begin
                case ({w_gen[i], w_take[i]})
                    2'b10: begin
                        if (r_credit == CMAX) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_credit <= r_credit + 1'b1;
                        end
                    end
                    2'b01:   r_credit <= r_credit - 1'b1;
                    default: r_credit <= r_credit;
                endcase
            end
        end
    end

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req        (w_req),
        .last_grant (r_last),
        .grant      (w_grant),
        .grant_idx  (w_gidx),
        .any_grant  (w_any)
    );

    // Output stage: load the granted channel, or go idle when nothing is pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bvalid <= 1'b0;
            r_bch    <= '0;
            r_last   <= CH_W'(N_CH - 1);
        end else if (w_load) begin
            if (w_any) begin
                r_bvalid <= 1'b1;
                r_bch    <= w_gidx;
                r_last   <= w_gidx;
            end else begin
                r_bvalid <= 1'b0;
            end
        end
    end

    assign b_valid = r_bvalid;
    assign b_ch    = r_bch;
    assign busy    = (|w_req) | r_bvalid;

endmodule
